// File: rtl/ctrl_pkg.sv
// Shared encodings for the multi-cycle RV32I control unit: FSM states, ALU ops,
// opcodes and the datapath mux selects.
package ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR, S_EXECR, S_EXECI,
    S_LUI, S_ALUWB, S_BRANCH, S_JAL, S_JALR, S_ALUWB_LINK, S_TRAP, S_MULWAIT
  } state_t;

  localparam logic [3:0] ALU_ADD   = 4'd0;
  localparam logic [3:0] ALU_SUB   = 4'd1;
  localparam logic [3:0] ALU_AND   = 4'd2;
  localparam logic [3:0] ALU_OR    = 4'd3;
  localparam logic [3:0] ALU_XOR   = 4'd4;
  localparam logic [3:0] ALU_SLL   = 4'd5;
  localparam logic [3:0] ALU_SRL   = 4'd6;
  localparam logic [3:0] ALU_SRA   = 4'd7;
  localparam logic [3:0] ALU_SLT   = 4'd8;
  localparam logic [3:0] ALU_SLTU  = 4'd9;
  localparam logic [3:0] ALU_PASSB = 4'd10;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  localparam logic [2:0] IMM_I = 3'd0;
  localparam logic [2:0] IMM_S = 3'd1;
  localparam logic [2:0] IMM_B = 3'd2;
  localparam logic [2:0] IMM_J = 3'd3;
  localparam logic [2:0] IMM_U = 3'd4;

  localparam logic [1:0] RES_ALUOUT = 2'd0;
  localparam logic [1:0] RES_MDR    = 2'd1;
  localparam logic [1:0] RES_ALU    = 2'd2;

  localparam logic [1:0] SRCA_PC    = 2'd0;
  localparam logic [1:0] SRCA_OLDPC = 2'd1;
  localparam logic [1:0] SRCA_RS1   = 2'd2;
  localparam logic [1:0] SRCB_RS2   = 2'd0;
  localparam logic [1:0] SRCB_IMM   = 2'd1;
  localparam logic [1:0] SRCB_FOUR  = 2'd2;

endpackage

// File: rtl/alu_decode.sv
// Combinational funct3/funct7[5] to ALU operation map for R-type and OP-IMM.
module alu_decode
  import ctrl_pkg::*;
#(
  parameter int ALU_CTRL_W = 4
) (
  input  logic [2:0]            funct3,
  input  logic                  funct7_5,
  input  logic                  is_imm,
  output logic [ALU_CTRL_W-1:0] alu_ctrl
);

  logic [3:0] op;

  always_comb begin
    op = ALU_ADD;
    case (funct3)
      // funct7[5] selects SUB only for register operands; in OP-IMM it is immediate bits
      3'b000:  op = (funct7_5 && !is_imm) ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = funct7_5 ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    alu_ctrl = ALU_CTRL_W'(op);
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32I control FSM with shared-memory handshake, timeout and sticky trap.
// Optional multiply/divide sequencing is enabled with `define MULDIV_EN.
module multicycle_ctrl
  import ctrl_pkg::*;
#(
  parameter int ALU_CTRL_W  = 4,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [31:0]           instr,
  input  logic                  mem_ready,
  input  logic                  EQ,
  input  logic                  LT,
  input  logic                  LTU,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic                  AddrSrc,
  output logic                  IRwrite,
  output logic                  PCwrite,
  output logic                  PCsrc,
  output logic [1:0]            ALUsrcA,
  output logic [1:0]            ALUsrcB,
  output logic [ALU_CTRL_W-1:0] ALUctrl,
  output logic [2:0]            ImmSrc,
  output logic [1:0]            ResultSrc,
  output logic                  RegWrite,
  output logic                  trap,
  output logic                  bus_err
`ifdef MULDIV_EN
  ,
  output logic                  md_start,
  output logic [2:0]            md_op,
  input  logic                  md_done
`endif
);

  state_t                state_q, state_d;
  logic [7:0]            tmo_q, tmo_d;
  logic                  bus_err_q, bus_err_d;
  logic [6:0]            opcode;
  logic [2:0]            funct3;
  logic [6:0]            funct7;
  logic [ALU_CTRL_W-1:0] dec_ctrl;
  logic [2:0]            imm_sel;
  logic                  br_taken;
  logic                  mem_wait;
  logic                  tmo_hit;
  logic                  unused_instr;

  assign opcode       = instr[6:0];
  assign funct3       = instr[14:12];
  assign funct7       = instr[31:25];
  assign unused_instr = ^{instr[24:15], instr[11:7]};

  alu_decode #(.ALU_CTRL_W(ALU_CTRL_W)) u_alu_decode (
    .funct3   (funct3),
    .funct7_5 (instr[30]),
    .is_imm   (state_q == S_EXECI),
    .alu_ctrl (dec_ctrl)
  );

  always_comb begin
    case (opcode)
      OP_STORE:  imm_sel = IMM_S;
      OP_BRANCH: imm_sel = IMM_B;
      OP_JAL:    imm_sel = IMM_J;
      OP_LUI:    imm_sel = IMM_U;
      default:   imm_sel = IMM_I;
    endcase
  end

  always_comb begin
    case (funct3)
      3'b000:  br_taken = EQ;
      3'b001:  br_taken = !EQ;
      3'b100:  br_taken = LT;
      3'b101:  br_taken = !LT;
      3'b110:  br_taken = LTU;
      3'b111:  br_taken = !LTU;
      default: br_taken = 1'b0;
    endcase
  end

  // A mem_ready on the final allowed cycle keeps mem_wait low, so ready wins over timeout
  assign mem_wait = ((state_q == S_FETCH) || (state_q == S_MEMRD) || (state_q == S_MEMWR))
                    && !mem_ready;
  assign tmo_hit  = mem_wait && (tmo_q == 8'(MEM_TIMEOUT - 1));

`ifdef MULDIV_EN
  logic md_busy_q, md_busy_d;
  logic md_wb_q, md_wb_d;
`endif

  always_comb begin
    state_d   = state_q;
    bus_err_d = bus_err_q;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    AddrSrc   = 1'b0;
    IRwrite   = 1'b0;
    PCwrite   = 1'b0;
    PCsrc     = 1'b0;
    ALUsrcA   = SRCA_PC;
    ALUsrcB   = SRCB_RS2;
    ALUctrl   = ALU_CTRL_W'(ALU_ADD);
    ImmSrc    = imm_sel;
    ResultSrc = RES_ALUOUT;
    RegWrite  = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_req = 1'b1;
        ALUsrcB = SRCB_FOUR;
        IRwrite = mem_ready;
        PCwrite = mem_ready;
        if (mem_ready) state_d = S_DECODE;
      end
      S_DECODE: begin
        ALUsrcA = SRCA_OLDPC;
        ALUsrcB = SRCB_IMM;
        case (opcode)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
`ifdef MULDIV_EN
          OP_R:      state_d = (funct7 == 7'b0000001) ? S_MULWAIT : S_EXECR;
`else
          OP_R:      state_d = (funct7 == 7'b0000001) ? S_TRAP : S_EXECR;
`endif
          OP_IMM:    state_d = S_EXECI;
          OP_BRANCH: state_d = S_BRANCH;
          OP_JAL:    state_d = S_JAL;
          OP_JALR:   state_d = S_JALR;
          OP_LUI:    state_d = S_LUI;
          default:   state_d = S_TRAP;
        endcase
      end
      S_MEMADR: begin
        ALUsrcA = SRCA_RS1;
        ALUsrcB = SRCB_IMM;
        state_d = (opcode == OP_STORE) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        mem_req = 1'b1;
        AddrSrc = 1'b1;
        if (mem_ready) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        RegWrite  = 1'b1;
        ResultSrc = RES_MDR;
        state_d   = S_FETCH;
      end
      S_MEMWR: begin
        mem_req = 1'b1;
        mem_we  = 1'b1;
        AddrSrc = 1'b1;
        if (mem_ready) state_d = S_FETCH;
      end
      S_EXECR, S_EXECI: begin
        ALUsrcA = SRCA_RS1;
        ALUsrcB = (state_q == S_EXECI) ? SRCB_IMM : SRCB_RS2;
        ALUctrl = dec_ctrl;
        state_d = S_ALUWB;
      end
      S_LUI: begin
        ALUsrcA = SRCA_RS1;
        ALUsrcB = SRCB_IMM;
        ALUctrl = ALU_CTRL_W'(ALU_PASSB);
        ImmSrc  = IMM_U;
        state_d = S_ALUWB;
      end
      S_ALUWB: begin
        RegWrite = 1'b1;
`ifdef MULDIV_EN
        ResultSrc = md_wb_q ? RES_ALU : RES_ALUOUT;
`endif
        state_d  = S_FETCH;
      end
      S_BRANCH: begin
        ALUsrcA = SRCA_RS1;
        ALUsrcB = SRCB_RS2;
        ALUctrl = ALU_CTRL_W'(ALU_SUB);
        PCsrc   = 1'b1;
        PCwrite = br_taken;
        state_d = (funct3[2:1] == 2'b01) ? S_TRAP : S_FETCH;
      end
      S_JAL: begin
        ALUsrcA = SRCA_OLDPC;
        ALUsrcB = SRCB_FOUR;
        PCwrite = 1'b1;
        PCsrc   = 1'b1;
        state_d = S_ALUWB;
      end
      S_JALR: begin
        ALUsrcA = SRCA_RS1;
        ALUsrcB = SRCB_IMM;
        PCwrite = 1'b1;
        state_d = S_ALUWB_LINK;
      end
      S_ALUWB_LINK: begin
        RegWrite  = 1'b1;
        ResultSrc = RES_ALU;
        ALUsrcA   = SRCA_OLDPC;
        ALUsrcB   = SRCB_FOUR;
        state_d   = S_FETCH;
      end
`ifdef MULDIV_EN
      S_MULWAIT: begin
        if (md_done) state_d = S_ALUWB;
      end
`endif
      S_TRAP:  state_d = S_TRAP;
      default: state_d = S_TRAP;
    endcase
    if (tmo_hit) begin
      state_d   = S_TRAP;
      bus_err_d = 1'b1;
    end
  end

  always_comb begin
    tmo_d = tmo_q;
    if (state_d != state_q) tmo_d = 8'd0;
    else if (mem_wait)      tmo_d = tmo_q + 8'd1;
  end

`ifdef MULDIV_EN
  assign md_busy_d = (state_q == S_MULWAIT) && (state_d == S_MULWAIT);
  assign md_wb_d   = (state_q == S_MULWAIT);
  assign md_start  = (state_q == S_MULWAIT) && !md_busy_q;
  assign md_op     = funct3;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      md_busy_q <= 1'b0;
      md_wb_q   <= 1'b0;
    end else begin
      md_busy_q <= md_busy_d;
      md_wb_q   <= md_wb_d;
    end
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_FETCH;
      tmo_q     <= 8'd0;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      tmo_q     <= tmo_d;
      bus_err_q <= bus_err_d;
    end
  end

  assign trap    = (state_q == S_TRAP);
  assign bus_err = bus_err_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed scoreboard bench for multicycle_ctrl: per-cycle expected outputs from a
// state-labelled reference table, compared with immediate assertions.
module tb_multicycle_ctrl;

  localparam logic [3:0] A_ADD = 4'd0, A_SUB = 4'd1, A_AND = 4'd2, A_SRL = 4'd6,
                         A_SRA = 4'd7, A_SLT = 4'd8, A_PASSB = 4'd10;
  localparam logic [2:0] I_I = 3'd0, I_S = 3'd1, I_B = 3'd2, I_J = 3'd3, I_U = 3'd4,
                         I_X = 3'd7;

  typedef enum {L_FETCH, L_DECODE, L_MEMADR, L_MEMRD, L_MEMWB, L_MEMWR, L_EXECR, L_EXECI,
                L_LUI, L_ALUWB, L_ALUWB_MD, L_BRANCH, L_JAL, L_JALR, L_LINK, L_TRAP,
                L_MULWAIT} lbl_t;

  typedef struct packed {
    logic       mem_req, mem_we, addr, irw, pcw, pcs, regw, trap, berr;
    logic [1:0] a, b, res;
    logic [3:0] alu;
    logic [2:0] imm;
  } ov_t;

  typedef struct {
    string tag;
    ov_t   v;
    ov_t   m;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instr;
  logic        mem_ready, EQ, LT, LTU;
  logic        mem_req, mem_we, AddrSrc, IRwrite, PCwrite, PCsrc, RegWrite, trap, bus_err;
  logic [1:0]  ALUsrcA, ALUsrcB, ResultSrc;
  logic [3:0]  ALUctrl;
  logic [2:0]  ImmSrc;
`ifdef MULDIV_EN
  logic        md_start, md_done;
  logic [2:0]  md_op;
`endif

  int   applied = 0;
  int   miscompares = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  multicycle_ctrl #(.ALU_CTRL_W(4), .MEM_TIMEOUT(15)) dut (
    .clk(clk), .rst(rst), .instr(instr), .mem_ready(mem_ready),
    .EQ(EQ), .LT(LT), .LTU(LTU),
    .mem_req(mem_req), .mem_we(mem_we), .AddrSrc(AddrSrc), .IRwrite(IRwrite),
    .PCwrite(PCwrite), .PCsrc(PCsrc), .ALUsrcA(ALUsrcA), .ALUsrcB(ALUsrcB),
    .ALUctrl(ALUctrl), .ImmSrc(ImmSrc), .ResultSrc(ResultSrc), .RegWrite(RegWrite),
    .trap(trap), .bus_err(bus_err)
`ifdef MULDIV_EN
    , .md_start(md_start), .md_op(md_op), .md_done(md_done)
`endif
  );

  function automatic exp_t model(string tag, lbl_t st, logic rdy, logic tk,
                                 logic [3:0] alu, logic [2:0] imm, logic berr);
    exp_t e;
    e.tag = tag;
    e.v = '0;
    e.m = '0;
    {e.m.mem_req, e.m.mem_we, e.m.irw, e.m.pcw, e.m.regw, e.m.trap, e.m.berr} = '1;
    case (st)
      L_FETCH: begin
        e.v.mem_req = 1'b1; e.v.irw = rdy; e.v.pcw = rdy;
        e.m.addr = 1'b1; e.m.pcs = 1'b1;
        e.m.a = '1; e.v.a = 2'd0; e.m.b = '1; e.v.b = 2'd2; e.m.alu = '1; e.v.alu = A_ADD;
      end
      L_DECODE: begin
        e.m.a = '1; e.v.a = 2'd1; e.m.b = '1; e.v.b = 2'd1; e.m.alu = '1; e.v.alu = A_ADD;
        if (imm != I_X) begin e.m.imm = '1; e.v.imm = imm; end
      end
      L_MEMADR: begin
        e.m.a = '1; e.v.a = 2'd2; e.m.b = '1; e.v.b = 2'd1; e.m.alu = '1; e.v.alu = A_ADD;
      end
      L_MEMRD: begin e.v.mem_req = 1'b1; e.m.addr = 1'b1; e.v.addr = 1'b1; end
      L_MEMWB: begin e.v.regw = 1'b1; e.m.res = '1; e.v.res = 2'd1; end
      L_MEMWR: begin
        e.v.mem_req = 1'b1; e.v.mem_we = 1'b1; e.m.addr = 1'b1; e.v.addr = 1'b1;
      end
      L_EXECR, L_EXECI: begin
        e.m.a = '1; e.v.a = 2'd2; e.m.b = '1; e.v.b = (st == L_EXECI) ? 2'd1 : 2'd0;
        e.m.alu = '1; e.v.alu = alu;
      end
      L_LUI: begin
        e.m.a = '1; e.v.a = 2'd2; e.m.b = '1; e.v.b = 2'd1;
        e.m.alu = '1; e.v.alu = A_PASSB; e.m.imm = '1; e.v.imm = I_U;
      end
      L_ALUWB:    begin e.v.regw = 1'b1; e.m.res = '1; e.v.res = 2'd0; end
      L_ALUWB_MD: begin e.v.regw = 1'b1; e.m.res = '1; e.v.res = 2'd2; end
      L_BRANCH: begin
        e.v.pcw = tk; e.m.pcs = 1'b1; e.v.pcs = 1'b1;
        e.m.a = '1; e.v.a = 2'd2; e.m.b = '1; e.v.b = 2'd0; e.m.alu = '1; e.v.alu = A_SUB;
      end
      L_JAL: begin
        e.v.pcw = 1'b1; e.m.pcs = 1'b1; e.v.pcs = 1'b1;
        e.m.a = '1; e.v.a = 2'd1; e.m.b = '1; e.v.b = 2'd2; e.m.alu = '1; e.v.alu = A_ADD;
      end
      L_JALR: begin
        e.v.pcw = 1'b1; e.m.pcs = 1'b1; e.v.pcs = 1'b0;
        e.m.a = '1; e.v.a = 2'd2; e.m.b = '1; e.v.b = 2'd1; e.m.alu = '1; e.v.alu = A_ADD;
      end
      L_LINK: begin
        e.v.regw = 1'b1; e.m.res = '1; e.v.res = 2'd2;
        e.m.a = '1; e.v.a = 2'd1; e.m.b = '1; e.v.b = 2'd2; e.m.alu = '1; e.v.alu = A_ADD;
      end
      L_TRAP: begin e.v.trap = 1'b1; e.v.berr = berr; end
      default: ;
    endcase
    return e;
  endfunction

  task automatic step(string tag, lbl_t st, logic tk = 1'b0, logic [3:0] alu = 4'd0,
                      logic [2:0] imm = 3'd7, logic berr = 1'b0);
    exp_t got;
    ov_t  obs;
    #1;
    sb.push_back(model(tag, st, mem_ready, tk, alu, imm, berr));
    got = sb.pop_front();
    obs = {mem_req, mem_we, AddrSrc, IRwrite, PCwrite, PCsrc, RegWrite, trap, bus_err,
           ALUsrcA, ALUsrcB, ResultSrc, ALUctrl, ImmSrc};
    applied++;
    assert ((obs & got.m) === (got.v & got.m)) else begin
      miscompares++;
      $error("FAIL %s: observed %h required %h", got.tag, obs & got.m, got.v & got.m);
    end
    @(negedge clk);
  endtask

  task automatic fd(string t, logic [31:0] w, logic [2:0] imm);
    mem_ready = 1'b1;
    instr = w;
    step({t, ".fetch"}, L_FETCH);
    step({t, ".dec"}, L_DECODE, 1'b0, A_ADD, imm);
  endtask

  task automatic rst_pulse(string t);
    rst = 1'b1;
    mem_ready = 1'b0;
    step(t, L_FETCH);
    rst = 1'b0;
  endtask

`ifdef MULDIV_EN
  task automatic md_chk(string tag, logic s_exp, logic [2:0] op_exp);
    #1;
    applied++;
    assert (md_start === s_exp && md_op === op_exp) else begin
      miscompares++;
      $error("FAIL %s: observed start=%b op=%0d required start=%b op=%0d",
             tag, md_start, md_op, s_exp, op_exp);
    end
  endtask
`endif

  initial begin
    rst = 1'b1; instr = '0; mem_ready = 1'b0; EQ = 1'b0; LT = 1'b0; LTU = 1'b0;
`ifdef MULDIV_EN
    md_done = 1'b0;
`endif
    repeat (2) @(negedge clk);
    step("reset", L_FETCH);
    rst = 1'b0;

    fd("addi", 32'h00500093, I_I);
    step("addi.ex", L_EXECI, 1'b0, A_ADD);
    step("addi.wb", L_ALUWB);

    EQ = 1'b1; fd("beq_t", 32'h00000463, I_B); step("beq_t.br", L_BRANCH, 1'b1);
    EQ = 1'b0; fd("beq_n", 32'h00000463, I_B); step("beq_n.br", L_BRANCH, 1'b0);
    EQ = 1'b1; fd("bne_n", 32'h00001463, I_B); step("bne_n.br", L_BRANCH, 1'b0);
    LT = 1'b1; fd("blt_t", 32'h0000C463, I_B); step("blt_t.br", L_BRANCH, 1'b1);
    LTU = 1'b0; fd("bgeu_t", 32'h0000F463, I_B); step("bgeu_t.br", L_BRANCH, 1'b1);
    EQ = 1'b0; LT = 1'b0;

    fd("sub", 32'h40208033, I_X);  step("sub.ex", L_EXECR, 1'b0, A_SUB);  step("sub.wb", L_ALUWB);
    fd("slt", 32'h0020A033, I_X);  step("slt.ex", L_EXECR, 1'b0, A_SLT);  step("slt.wb", L_ALUWB);
    fd("and", 32'h0020F033, I_X);  step("and.ex", L_EXECR, 1'b0, A_AND);  step("and.wb", L_ALUWB);
    fd("addi_hi", 32'h40000093, I_I); step("addi_hi.ex", L_EXECI, 1'b0, A_ADD); step("addi_hi.wb", L_ALUWB);
    fd("srai", 32'h4010D093, I_I); step("srai.ex", L_EXECI, 1'b0, A_SRA); step("srai.wb", L_ALUWB);
    fd("srli", 32'h0010D093, I_I); step("srli.ex", L_EXECI, 1'b0, A_SRL); step("srli.wb", L_ALUWB);

    fd("lui", 32'h123450B7, I_U);  step("lui.ex", L_LUI);   step("lui.wb", L_ALUWB);
    fd("jal", 32'h008000EF, I_J);  step("jal.ex", L_JAL);   step("jal.wb", L_ALUWB);
    fd("jalr", 32'h000080E7, I_I); step("jalr.ex", L_JALR); step("jalr.link", L_LINK);

    fd("lw", 32'h0000A103, I_I);
    step("lw.adr", L_MEMADR);
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) step("lw.rd_wait", L_MEMRD);
    mem_ready = 1'b1;
    step("lw.rd", L_MEMRD);
    step("lw.wb", L_MEMWB);

    fd("sw", 32'h0020A023, I_S);
    step("sw.adr", L_MEMADR);
    step("sw.wr", L_MEMWR);

    fd("lw_edge", 32'h0000A103, I_I);
    step("lw_edge.adr", L_MEMADR);
    mem_ready = 1'b0;
    for (int i = 0; i < 14; i++) step("lw_edge.rd_wait", L_MEMRD);
    mem_ready = 1'b1;
    step("lw_edge.rd_last", L_MEMRD);
    step("lw_edge.wb", L_MEMWB);

    fd("lw_abort", 32'h0000A103, I_I);
    step("lw_abort.adr", L_MEMADR);
    mem_ready = 1'b0;
    step("lw_abort.rd_wait", L_MEMRD);
    rst_pulse("lw_abort.rst");

    mem_ready = 1'b0;
    for (int i = 0; i < 15; i++) step("tmo.fetch_wait", L_FETCH);
    step("tmo.trap", L_TRAP, 1'b0, 4'd0, 3'd7, 1'b1);
    mem_ready = 1'b1;
    step("tmo.trap_hold", L_TRAP, 1'b0, 4'd0, 3'd7, 1'b1);
    rst_pulse("tmo.rst");

    fd("illegal", 32'h00000000, I_X);
    mem_ready = 1'b1; EQ = 1'b1; LT = 1'b1; LTU = 1'b1;
    for (int i = 0; i < 100; i++) step("illegal.trap", L_TRAP);
    rst_pulse("illegal.rst");

    fd("br010", 32'h00002463, I_B);
    EQ = 1'b1; LT = 1'b1; LTU = 1'b1;
    step("br010.br", L_BRANCH, 1'b0);
    step("br010.trap", L_TRAP);
    rst_pulse("br010.rst");
    EQ = 1'b0; LT = 1'b0; LTU = 1'b0;

    fd("mul", 32'h022081B3, I_X);
`ifdef MULDIV_EN
    md_chk("mul.start", 1'b1, 3'd0);
    step("mul.wait0", L_MULWAIT);
    md_chk("mul.nostart", 1'b0, 3'd0);
    step("mul.wait1", L_MULWAIT);
    md_done = 1'b1;
    md_chk("mul.done", 1'b0, 3'd0);
    step("mul.wait2", L_MULWAIT);
    md_done = 1'b0;
    step("mul.wb", L_ALUWB_MD);
`else
    step("mul.trap", L_TRAP);
    rst_pulse("mul.rst");
`endif

    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end

endmodule
